mc_residual_stream: RTL and testbench
=====================================

// Module: mc_residual_stream
// PURPOSE
//  Row-serial motion-compensation residual generator: next generation of the 4x4 mc_lc block.
//  Accepts one MB row (curr + ref) per beat; emits signed residual row, last-row flag, block SAD.
//  Inter mode: curr-ref. Bypass mode: ref forced to 0 (intra/PCM path).
//  Sits between motion estimation/ref fetch and the forward transform; valid/ready on both sides.
// PARAMETERS
//  MB_SIZE      4  pixels per row and rows per block (power of two, >=2)
//  PIXEL_WIDTH  8  unsigned pixel width
//  RES_W   derived PIXEL_WIDTH+1  signed residual width
//  SAD_W   derived PIXEL_WIDTH+2*$clog2(MB_SIZE)  block SAD width (no overflow possible)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  reset      in   1                   asynchronous, active-low reset
//  mode       in   1                   0=inter (curr-ref), 1=bypass (curr-0); sampled on row 0
//  curr_row   in   PIXEL_WIDTH x MB_SIZE  current MB row, unpacked [0:MB_SIZE-1]
//  ref_row    in   PIXEL_WIDTH x MB_SIZE  reference row, unpacked [0:MB_SIZE-1]
//  src_valid  in   1                   input row valid
//  src_ready  out  1                   input row accepted when src_valid&src_ready
//  residual   out  RES_W x MB_SIZE     signed residual row
//  dst_last   out  1                   residual is row MB_SIZE-1 of its block
//  dst_sad    out  SAD_W               block SAD; meaningful only when dst_last=1, else 0
//  dst_valid  out  1                   output row valid
//  dst_ready  in   1                   downstream accepts when dst_valid&dst_ready
// BEHAVIOUR
//  - Reset (reset=0, async): src_ready=0, dst_valid=0, dst_last=0, dst_sad=0, residual=0;
//    row counter, SAD accumulator, block mode, FIFO pointers cleared. src_ready=1 from 1st edge after release.
//  - Reset mid-block: partial block discarded; next accepted row is row 0.
//  - Row counter 0..MB_SIZE-1, advances per accepted input; wraps to 0 after MB_SIZE-1.
//  - mode latched on row-0 acceptance, held for whole block; mode changes mid-block ignored.
//  - Per lane: residual = $signed({1'b0,curr}) - $signed({1'b0,(mode?0:ref)}); range +/-(2^PW-1).
//  - SAD: accumulator += sum|residual| per accepted row; on row MB_SIZE-1 the full sum is
//    pushed with the row and accumulator cleared same edge (back-to-back blocks, no bubble).
//  - Output buffer: 2-entry FIFO {residual,last,sad}. Latency: accepted at edge N -> dst_valid
//    after edge N (visible cycle N+1) if FIFO empty. Throughput 1 row/cycle when dst_ready=1.
//  - src_ready = (fifo_count<2) | (fifo_count==2 & ... not used): src_ready = fifo_count<2, registered-
//    state only, no combinational path from dst_ready to src_ready.
//  - Simultaneous push+pop: count unchanged; legal at count 0..1 (push), 1..2 (pop).
//  - dst_valid=1 and outputs stable until handshake (AXI-style; no retraction).
//  - Full: src_ready=0, input ignored, row counter/accumulator frozen. Empty: dst_valid=0.
// STRUCTURE
//  - Package mc_pkg: pixel_t, residual_t (signed RES_W), sad_t, typedef enum logic {MC_INTER,
//    MC_BYPASS} mc_mode_e, packed struct mc_res_beat_t {residual row, last, sad}.
//  - Sub-module mc_skid_fifo: 2-entry FIFO of mc_res_beat_t, count/ptr logic, async active-low reset.
//  - Top: lane subtractors + abs adder tree (combinational), row counter, mode latch, SAD accumulator.
// TESTING
//  1 Inter block, dst_ready=1: curr rows {16,15,14,13},{12,11,10,9},{8,7,6,5},{4,3,2,1}, ref rows
//    {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> residual {15,13,11,9},{7,5,3,1},
//    {-1,-3,-5,-7},{-9,-11,-13,-15}; dst_last only on 4th; dst_sad=128; 1-cycle latency.
//  2 Bypass: same data, mode=1 on row 0 -> residual == curr rows; dst_sad=136; flip mode to 0 on
//    row 2 -> no effect within block.
//  3 Extremes: curr all 0/ref all 255 -> -255 each lane; curr 255/ref 0 -> +255; block of
//    alternating such rows -> dst_sad=4080 (max, no wrap in 12 bits).
//  4 Backpressure: dst_ready=0 for 5 cycles with src_valid=1 -> exactly 2 rows accepted, src_ready=0,
//    outputs held stable; release -> rows emerge in order, none lost/duplicated.
//  5 Back-to-back blocks, 8 consecutive rows -> two dst_last pulses, SADs independent (128, 128).
//  6 Reset low after row 2 accepted -> all outputs 0 async; after release, new block starts at row 0,
//    dst_last on its 4th row, SAD excludes pre-reset rows.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the row-serial motion-compensation residual path.
package mc_pkg;

  localparam int unsigned MC_MB_SIZE     = 4;
  localparam int unsigned MC_PIXEL_WIDTH = 8;
  localparam int unsigned MC_RES_W       = MC_PIXEL_WIDTH + 1;
  localparam int unsigned MC_SAD_W       = MC_PIXEL_WIDTH + 2 * $clog2(MC_MB_SIZE);

  typedef logic        [MC_PIXEL_WIDTH-1:0] pixel_t;
  typedef logic signed [MC_RES_W-1:0]       residual_t;
  typedef logic        [MC_SAD_W-1:0]       sad_t;

  typedef enum logic {
    MC_INTER  = 1'b0,
    MC_BYPASS = 1'b1
  } mc_mode_e;

  // One output beat: residual row, last-row flag, block SAD (zero unless last)
  typedef struct packed {
    residual_t [MC_MB_SIZE-1:0] residual;
    logic                       last;
    sad_t                       sad;
  } mc_res_beat_t;

endpackage

// File: rtl/mc_skid_fifo.sv
// Two-entry output FIFO; ready/valid flags are registered from next-state count.
module mc_skid_fifo
  import mc_pkg::*;
#(
  parameter type beat_t = mc_res_beat_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  beat_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_d;
  logic       push;
  logic       pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next occupancy; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + 2'd1;
      2'b01:   count_d = count - 2'd1;
      default: count_d = count;
    endcase
  end

  // Storage, pointers and registered flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count     <= count_d;
      in_ready  <= (count_d != 2'd2);
      out_valid <= (count_d != 2'd0);
    end
  end

  assign out_beat = mem[rd_ptr];

endmodule

// File: rtl/mc_residual_stream.sv
// Row-serial MC residual generator: per-lane curr-ref, block SAD, buffered output.
module mc_residual_stream
  import mc_pkg::*;
#(
  parameter int unsigned MB_SIZE     = MC_MB_SIZE,
  parameter int unsigned PIXEL_WIDTH = MC_PIXEL_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         mode,
  input  logic        [PIXEL_WIDTH-1:0]                curr_row [0:MB_SIZE-1],
  input  logic        [PIXEL_WIDTH-1:0]                ref_row  [0:MB_SIZE-1],
  input  logic                                         src_valid,
  output logic                                         src_ready,
  output logic signed [PIXEL_WIDTH:0]                  residual [0:MB_SIZE-1],
  output logic                                         dst_last,
  output logic        [PIXEL_WIDTH+2*$clog2(MB_SIZE)-1:0] dst_sad,
  output logic                                         dst_valid,
  input  logic                                         dst_ready
);

  localparam int unsigned RES_W = PIXEL_WIDTH + 1;
  localparam int unsigned ROW_W = $clog2(MB_SIZE);
  localparam int unsigned SUM_W = PIXEL_WIDTH + ROW_W;
  localparam int unsigned SAD_W = PIXEL_WIDTH + 2 * ROW_W;

  typedef struct packed {
    logic [MB_SIZE-1:0][RES_W-1:0] residual;
    logic                          last;
    logic [SAD_W-1:0]              sad;
  } beat_t;

  logic [ROW_W-1:0]              row_cnt;
  mc_mode_e                      mode_q;
  mc_mode_e                      eff_mode_c;
  logic [MB_SIZE-1:0][RES_W-1:0] res_c;
  logic [SUM_W-1:0]              row_sum_c;
  logic [SAD_W-1:0]              acc_q;
  logic [SAD_W-1:0]              acc_sum_c;
  logic                          row_last_c;
  logic                          push;
  beat_t                         push_beat;
  beat_t                         out_beat;

  assign push       = src_valid & src_ready;
  assign row_last_c = (row_cnt == ROW_W'(MB_SIZE - 1));

  // Row 0 takes the live mode; later rows use the mode latched for the block
  always_comb begin
    eff_mode_c = mode_q;
    if (row_cnt == '0) eff_mode_c = mc_mode_e'(mode);
  end

  // Lane subtractors and absolute-value adder tree
  always_comb begin
    logic [PIXEL_WIDTH-1:0] ref_eff;
    logic [PIXEL_WIDTH-1:0] mag;
    ref_eff   = '0;
    mag       = '0;
    res_c     = '0;
    row_sum_c = '0;
    for (int unsigned i = 0; i < MB_SIZE; i++) begin
      ref_eff  = (eff_mode_c == MC_BYPASS) ? '0 : ref_row[i];
      // Zero-extended 9-bit difference is the exact two's-complement residual
      res_c[i] = {1'b0, curr_row[i]} - {1'b0, ref_eff};
      mag      = res_c[i][RES_W-1] ? PIXEL_WIDTH'(-res_c[i]) : res_c[i][PIXEL_WIDTH-1:0];
      row_sum_c = row_sum_c + SUM_W'(mag);
    end
  end

  // Beat pushed into the output buffer; SAD only carried on the last row
  always_comb begin
    acc_sum_c          = acc_q + SAD_W'(row_sum_c);
    push_beat.residual = res_c;
    push_beat.last     = row_last_c;
    push_beat.sad      = row_last_c ? acc_sum_c : '0;
  end

  // Row counter, block mode latch and SAD accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt <= '0;
      mode_q  <= MC_INTER;
      acc_q   <= '0;
    end else if (push) begin
      row_cnt <= row_last_c ? '0 : row_cnt + ROW_W'(1);
      if (row_cnt == '0) mode_q <= eff_mode_c;
      acc_q   <= row_last_c ? '0 : acc_sum_c;
    end
  end

  mc_skid_fifo #(
    .beat_t(beat_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_valid (src_valid),
    .in_ready (src_ready),
    .in_beat  (push_beat),
    .out_valid(dst_valid),
    .out_ready(dst_ready),
    .out_beat (out_beat)
  );

  // Unpack the head beat onto the output ports
  always_comb begin
    for (int unsigned i = 0; i < MB_SIZE; i++) residual[i] = $signed(out_beat.residual[i]);
    dst_last = out_beat.last;
    dst_sad  = out_beat.sad;
  end

endmodule

// File: tb/tb_mc_residual_stream.sv
// Scoreboard bench for mc_residual_stream: directed rows, queued expectations.
module tb_mc_residual_stream;

  typedef int row4_t [4];
  typedef row4_t blk_t [4];
  typedef struct packed {
    logic [3:0][15:0] res;
    logic             last;
    logic [15:0]      sad;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mode = 1'b0;
  logic        [7:0] curr_row [0:3];
  logic        [7:0] ref_row  [0:3];
  logic              src_valid = 1'b0;
  logic              src_ready;
  logic signed [8:0] residual [0:3];
  logic              dst_last;
  logic       [11:0] dst_sad;
  logic              dst_valid;
  logic              dst_ready = 1'b1;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   accepted = 0;

  blk_t ac = '{'{16, 15, 14, 13}, '{12, 11, 10, 9}, '{8, 7, 6, 5}, '{4, 3, 2, 1}};
  blk_t ar = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};
  blk_t ae = '{'{15, 13, 11, 9}, '{7, 5, 3, 1}, '{-1, -3, -5, -7}, '{-9, -11, -13, -15}};
  row4_t zeros = '{0, 0, 0, 0};
  row4_t fulls = '{255, 255, 255, 255};
  row4_t negs  = '{-255, -255, -255, -255};

  always #5 clk = ~clk;

  mc_residual_stream dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .curr_row (curr_row),
    .ref_row  (ref_row),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .residual (residual),
    .dst_last (dst_last),
    .dst_sad  (dst_sad),
    .dst_valid(dst_valid),
    .dst_ready(dst_ready)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Present one row; push its expectation once it is seen to be accepted
  task automatic send(input row4_t c, input row4_t r, input bit m,
                      input row4_t e, input bit el, input int es);
    exp_t x;
    int   waited = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      curr_row[i] = 8'(c[i]);
      ref_row[i]  = 8'(r[i]);
      x.res[i]    = 16'(e[i]);
    end
    x.last    = el;
    x.sad     = 16'(es);
    mode      = m;
    src_valid = 1'b1;
    while (!src_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!src_ready) begin
      check("src_ready_timeout", int'(src_ready), 1);
      src_valid = 1'b0;
      return;
    end
    exp_q.push_back(x);
    accepted++;
    @(posedge clk);
    #1 src_valid = 1'b0;
  endtask

  task automatic send_block(input blk_t c, input blk_t r, input blk_t e, input int sad);
    for (int k = 0; k < 4; k++) send(c[k], r[k], 1'b0, e[k], k == 3, (k == 3) ? sad : 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare on each handshake, and check stability while stalled
  initial begin
    exp_t             e;
    logic [3:0][15:0] cur;
    logic [3:0][15:0] hold_res;
    logic             hold_last;
    logic [15:0]      hold_sad;
    bit               hold_v;
    hold_v    = 1'b0;
    hold_res  = '0;
    hold_last = 1'b0;
    hold_sad  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("valid_held", int'(dst_valid), 1);
        if (dst_valid) begin
          for (int i = 0; i < 4; i++) cur[i] = 16'(residual[i]);
          if (hold_v) begin
            check("held_residual", int'(cur == hold_res), 1);
            check("held_last", int'(dst_last), int'(hold_last));
            check("held_sad", int'(dst_sad), int'(hold_sad));
          end
          if (dst_ready) begin
            hold_v = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_beat: got beat with sad %0d, expected none", dst_sad);
            end else begin
              checks--;
              e = exp_q.pop_front();
              for (int i = 0; i < 4; i++)
                check($sformatf("residual[%0d]", i), int'(residual[i]), int'($signed(e.res[i])));
              check("dst_last", int'(dst_last), int'(e.last));
              check("dst_sad", int'(dst_sad), int'(e.sad));
            end
          end else begin
            hold_v    = 1'b1;
            hold_res  = cur;
            hold_last = dst_last;
            hold_sad  = 16'(dst_sad);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    for (int i = 0; i < 4; i++) begin
      curr_row[i] = 8'd0;
      ref_row[i]  = 8'd0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_src_ready", int'(src_ready), 0);
    check("rst_dst_valid", int'(dst_valid), 0);
    check("rst_dst_last", int'(dst_last), 0);
    check("rst_dst_sad", int'(dst_sad), 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_src_ready_low", int'(src_ready), 0);
    @(posedge clk);
    #1 check("rel_src_ready_high", int'(src_ready), 1);

    // 1: inter block with one-cycle latency on the first row
    send(ac[0], ar[0], 1'b0, ae[0], 1'b0, 0);
    #1 check("latency_dst_valid", int'(dst_valid), 1);
    for (int k = 1; k < 4; k++) send(ac[k], ar[k], 1'b0, ae[k], k == 3, (k == 3) ? 128 : 0);
    drain();

    // 2: bypass block; mode drop on row 2 has no effect
    send(ac[0], ar[0], 1'b1, ac[0], 1'b0, 0);
    send(ac[1], ar[1], 1'b1, ac[1], 1'b0, 0);
    send(ac[2], ar[2], 1'b0, ac[2], 1'b0, 0);
    send(ac[3], ar[3], 1'b0, ac[3], 1'b1, 136);
    drain();

    // 3: extremes, alternating rows, maximum SAD
    send(zeros, fulls, 1'b0, negs, 1'b0, 0);
    send(fulls, zeros, 1'b0, fulls, 1'b0, 0);
    send(zeros, fulls, 1'b0, negs, 1'b0, 0);
    send(fulls, zeros, 1'b0, fulls, 1'b1, 4080);
    drain();

    // 4: backpressure for five cycles
    @(negedge clk);
    dst_ready = 1'b0;
    acc0 = accepted;
    fork
      send_block(ac, ar, ae, 128);
      begin
        repeat (5) @(negedge clk);
        #1;
        check("bp_accepted", accepted - acc0, 2);
        check("bp_src_ready", int'(src_ready), 0);
        check("bp_dst_valid", int'(dst_valid), 1);
        dst_ready = 1'b1;
      end
    join
    drain();

    // 5: back-to-back blocks
    send_block(ac, ar, ae, 128);
    send_block(ac, ar, ae, 128);
    drain();

    // 6: reset mid-block discards the partial block
    for (int k = 0; k < 3; k++) send(ac[k], ar[k], 1'b0, ae[k], 1'b0, 0);
    drain();
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_dst_valid", int'(dst_valid), 0);
    check("mid_rst_src_ready", int'(src_ready), 0);
    check("mid_rst_dst_last", int'(dst_last), 0);
    check("mid_rst_dst_sad", int'(dst_sad), 0);
    for (int i = 0; i < 4; i++) check($sformatf("mid_rst_residual[%0d]", i), int'(residual[i]), 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mid_rel_src_ready_low", int'(src_ready), 0);
    @(posedge clk);
    #1 check("mid_rel_src_ready_high", int'(src_ready), 1);
    send_block(ac, ar, ae, 128);
    drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
